// File: rtl/sd_stream_pkg.sv
// Shared types and helpers for the SD sector streamer.
package sd_stream_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE    = 3'd1,
        WAIT_ACK = 3'd2,
        READ     = 3'd3,
        NEXT     = 3'd4
    } stream_state_e;

    // Address increment between consecutive sectors: byte addressing (SDSC)
    // moves by a whole sector, block addressing (SDHC) moves by one.
    function automatic logic [31:0] addr_step(input logic byte_addressed,
                                              input int unsigned sector_bytes);
        logic [31:0] step_v;
        if (byte_addressed) begin
            step_v = sector_bytes[31:0];
        end else begin
            step_v = 32'd1;
        end
        return step_v;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with a free-entry count.
// DEPTH must be a power of two; the head entry is visible on pop_data
// whenever empty is low.
module sync_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] free_count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign push_ok_s  = push && (count_r != FULL_COUNT);
    assign pop_ok_s   = pop && (count_r != {(AW+1){1'b0}});
    assign pop_data   = mem_r[rd_ptr_r];
    assign empty      = (count_r == {(AW+1){1'b0}});
    assign free_count = FULL_COUNT - count_r;

    // Storage array write port; contents need no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s && !flush) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Read/write pointers and occupancy, with flush taking priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/sd_sector_streamer.sv
// Reads NUM_FRAMES consecutive sectors through the sd_controller read port
// and streams the bytes out over valid/ready with a last-byte marker.
// rst_in is expected to reset the attached sd_controller as well.
module sd_sector_streamer
    import sd_stream_pkg::*;
#(
    parameter int unsigned SECTOR_BYTES   = 512,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned FRAME_W        = 16,
    parameter int unsigned FIFO_DEPTH     = 1024,
    parameter bit          BYTE_ADDRESSED = 1'b1,
    parameter int unsigned TIMEOUT_CYC    = 2_000_000
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               start_in,
    input  logic               stop_in,
    input  logic               loop_in,
    input  logic [ADDR_W-1:0]  start_addr_in,
    input  logic [FRAME_W-1:0] num_frames_in,
    input  logic               sd_ready_in,
    input  logic               sd_byte_avail_in,
    input  logic [7:0]         sd_dout_in,
    output logic               sd_rd_out,
    output logic [ADDR_W-1:0]  sd_addr_out,
    output logic [7:0]         data_out,
    output logic               valid_out,
    input  logic               ready_in,
    output logic               last_out,
    output logic               busy_out,
    output logic [FRAME_W-1:0] frame_idx_out,
    output logic               done_out,
    output logic               error_out
);
    localparam int unsigned BW  = $clog2(SECTOR_BYTES + 1);
    localparam int unsigned TW  = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned FCW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(addr_step(BYTE_ADDRESSED, SECTOR_BYTES));
    localparam logic [BW-1:0]     BYTE_LAST = BW'(SECTOR_BYTES - 1);
    localparam logic [TW-1:0]     TMO_HIT   = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0]     TMO_MAX   = TW'(TIMEOUT_CYC);

    stream_state_e      state_r;
    logic [ADDR_W-1:0]  addr_r;
    logic [ADDR_W-1:0]  start_addr_r;
    logic [ADDR_W-1:0]  sd_addr_r;
    logic [FRAME_W-1:0] count_r;
    logic [FRAME_W-1:0] frame_idx_r;
    logic [BW-1:0]      byte_cnt_r;
    logic [TW-1:0]      tmo_cnt_r;
    logic               stop_pend_r;
    logic               done_r;
    logic               error_r;
    logic               rd_r;
    logic               avail_prev_r;

    logic               byte_edge_s;
    logic               push_s;
    logic               last_tag_s;
    logic               tmo_hit_s;
    logic               space_ok_s;
    logic               pop_s;
    logic               fifo_empty_s;
    logic [8:0]         fifo_head_s;
    logic [FCW-1:0]     fifo_free_s;

    assign byte_edge_s = sd_byte_avail_in && !avail_prev_r;
    // A byte arriving on the deadline cycle still counts as activity.
    assign tmo_hit_s   = ((state_r == WAIT_ACK) || (state_r == READ)) &&
                         (tmo_cnt_r == TMO_HIT) &&
                         !((state_r == READ) && byte_edge_s);
    assign push_s      = (state_r == READ) && byte_edge_s && !tmo_hit_s;
    assign last_tag_s  = (byte_cnt_r == BYTE_LAST) &&
                         (frame_idx_r == (count_r - FRAME_W'(1))) && !loop_in;
    assign space_ok_s  = (fifo_free_s >= FCW'(SECTOR_BYTES));
    assign pop_s       = valid_out && ready_in;

    assign sd_rd_out     = rd_r;
    assign sd_addr_out   = sd_addr_r;
    assign data_out      = fifo_head_s[7:0];
    assign valid_out     = !fifo_empty_s;
    assign last_out      = !fifo_empty_s && fifo_head_s[8];
    assign busy_out      = (state_r != IDLE) || !fifo_empty_s;
    assign frame_idx_out = frame_idx_r;
    assign done_out      = done_r;
    assign error_out     = error_r;

    sync_fifo #(
        .WIDTH (9),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk_in),
        .rst_n      (rst_in),
        .flush      (tmo_hit_s),
        .push       (push_s),
        .push_data  ({last_tag_s, sd_dout_in}),
        .pop        (pop_s),
        .pop_data   (fifo_head_s),
        .empty      (fifo_empty_s),
        .free_count (fifo_free_s)
    );

    // Previous byte_available level, for rising-edge detection.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            avail_prev_r <= 1'b0;
        end else begin
            avail_prev_r <= sd_byte_avail_in;
        end
    end

    // Sector fetch sequencer with timeout supervision and stop handling.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_r      <= IDLE;
            addr_r       <= {ADDR_W{1'b0}};
            start_addr_r <= {ADDR_W{1'b0}};
            sd_addr_r    <= {ADDR_W{1'b0}};
            count_r      <= {FRAME_W{1'b0}};
            frame_idx_r  <= {FRAME_W{1'b0}};
            byte_cnt_r   <= {BW{1'b0}};
            tmo_cnt_r    <= {TW{1'b0}};
            stop_pend_r  <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
            rd_r         <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (tmo_cnt_r != TMO_MAX) begin
                tmo_cnt_r <= tmo_cnt_r + TW'(1);
            end
            if (stop_in && (state_r != IDLE)) begin
                stop_pend_r <= 1'b1;
            end
            if (tmo_hit_s) begin
                error_r     <= 1'b1;
                rd_r        <= 1'b0;
                stop_pend_r <= 1'b0;
                tmo_cnt_r   <= {TW{1'b0}};
                state_r     <= IDLE;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (start_in) begin
                            error_r <= 1'b0;
                            if (num_frames_in != {FRAME_W{1'b0}}) begin
                                start_addr_r <= start_addr_in;
                                addr_r       <= start_addr_in;
                                count_r      <= num_frames_in;
                                frame_idx_r  <= {FRAME_W{1'b0}};
                                byte_cnt_r   <= {BW{1'b0}};
                                stop_pend_r  <= 1'b0;
                                tmo_cnt_r    <= {TW{1'b0}};
                                state_r      <= ISSUE;
                            end else begin
                                done_r <= 1'b1;
                            end
                        end
                    end
                    ISSUE: begin
                        // Nothing in flight yet, so a pending stop ends here.
                        if (stop_pend_r) begin
                            done_r      <= 1'b1;
                            stop_pend_r <= 1'b0;
                            tmo_cnt_r   <= {TW{1'b0}};
                            state_r     <= IDLE;
                        end else if (sd_ready_in && space_ok_s) begin
                            rd_r      <= 1'b1;
                            sd_addr_r <= addr_r;
                            tmo_cnt_r <= {TW{1'b0}};
                            state_r   <= WAIT_ACK;
                        end
                    end
                    WAIT_ACK: begin
                        if (!sd_ready_in) begin
                            rd_r      <= 1'b0;
                            tmo_cnt_r <= {TW{1'b0}};
                            state_r   <= READ;
                        end
                    end
                    READ: begin
                        if (push_s) begin
                            tmo_cnt_r <= {TW{1'b0}};
                            if (byte_cnt_r == BYTE_LAST) begin
                                byte_cnt_r  <= {BW{1'b0}};
                                frame_idx_r <= frame_idx_r + FRAME_W'(1);
                                addr_r      <= addr_r + ADDR_STEP;
                                state_r     <= NEXT;
                            end else begin
                                byte_cnt_r <= byte_cnt_r + BW'(1);
                            end
                        end
                    end
                    NEXT: begin
                        tmo_cnt_r <= {TW{1'b0}};
                        if (stop_pend_r || stop_in) begin
                            done_r      <= 1'b1;
                            stop_pend_r <= 1'b0;
                            state_r     <= IDLE;
                        end else if (frame_idx_r == count_r) begin
                            if (loop_in) begin
                                addr_r      <= start_addr_r;
                                frame_idx_r <= {FRAME_W{1'b0}};
                                state_r     <= ISSUE;
                            end else begin
                                done_r  <= 1'b1;
                                state_r <= IDLE;
                            end
                        end else begin
                            state_r <= ISSUE;
                        end
                    end
                    default: begin
                        rd_r    <= 1'b0;
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sd_sector_streamer.sv
// Self-checking bench for sd_sector_streamer: two instances (byte and block
// addressing) share one sd_controller model and one consumer, selected by sel.
module tb_sd_sector_streamer;
    localparam int SB = 512;

    logic        clk = 1'b0;
    logic        rst_n, start, stop, loop_en, ready, sel, m_clr;
    logic [31:0] start_addr;
    logic [15:0] num_frames;

    // sd_controller model state
    logic        m_ready, m_avail, m_busy;
    logic [7:0]  m_dout;
    logic [31:0] m_addr;
    int          m_cnt, stall_after;
    logic [31:0] addr_log [16];
    int          addr_n;

    // Consumer log
    logic [8:0]  rx_q [$];
    int          done_cnt;
    logic [31:0] exp_addrs [8];
    int          n_checks, n_fail;

    logic        s0_start, s1_start;
    logic        d0_rd, d1_rd, d0_valid, d1_valid, d0_last, d1_last;
    logic        d0_busy, d1_busy, d0_done, d1_done, d0_err, d1_err;
    logic [31:0] d0_addr, d1_addr;
    logic [7:0]  d0_data, d1_data;
    logic [15:0] d0_fidx, d1_fidx;
    logic        rd_m, valid_m, last_m, busy_m, done_m, err_m;
    logic [31:0] addr_m;
    logic [7:0]  data_m;
    logic [15:0] fidx_m;

    always #20 clk = ~clk;

    assign s0_start = start && !sel;
    assign s1_start = start && sel;
    assign rd_m    = sel ? d1_rd    : d0_rd;
    assign addr_m  = sel ? d1_addr  : d0_addr;
    assign valid_m = sel ? d1_valid : d0_valid;
    assign last_m  = sel ? d1_last  : d0_last;
    assign busy_m  = sel ? d1_busy  : d0_busy;
    assign done_m  = sel ? d1_done  : d0_done;
    assign err_m   = sel ? d1_err   : d0_err;
    assign data_m  = sel ? d1_data  : d0_data;
    assign fidx_m  = sel ? d1_fidx  : d0_fidx;

    sd_sector_streamer #(.BYTE_ADDRESSED(1'b1), .TIMEOUT_CYC(1000)) dut0 (
        .clk_in(clk), .rst_in(rst_n), .start_in(s0_start), .stop_in(stop),
        .loop_in(loop_en), .start_addr_in(start_addr), .num_frames_in(num_frames),
        .sd_ready_in(m_ready), .sd_byte_avail_in(m_avail), .sd_dout_in(m_dout),
        .sd_rd_out(d0_rd), .sd_addr_out(d0_addr), .data_out(d0_data),
        .valid_out(d0_valid), .ready_in(ready), .last_out(d0_last),
        .busy_out(d0_busy), .frame_idx_out(d0_fidx), .done_out(d0_done),
        .error_out(d0_err));

    sd_sector_streamer #(.BYTE_ADDRESSED(1'b0), .TIMEOUT_CYC(1000)) dut1 (
        .clk_in(clk), .rst_in(rst_n), .start_in(s1_start), .stop_in(stop),
        .loop_in(loop_en), .start_addr_in(start_addr), .num_frames_in(num_frames),
        .sd_ready_in(m_ready), .sd_byte_avail_in(m_avail), .sd_dout_in(m_dout),
        .sd_rd_out(d1_rd), .sd_addr_out(d1_addr), .data_out(d1_data),
        .valid_out(d1_valid), .ready_in(ready), .last_out(d1_last),
        .busy_out(d1_busy), .frame_idx_out(d1_fidx), .done_out(d1_done),
        .error_out(d1_err));

    function automatic logic [7:0] pat(input logic [31:0] a, input int i);
        logic [7:0] r;
        r = a[7:0] + a[15:8] + 8'(i) + (8'(i >> 8) * 8'd53);
        return r;
    endfunction

    // sd_controller model: accepts rd, drops ready, toggles byte_available.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || m_clr) begin
            m_ready <= 1'b1; m_avail <= 1'b0; m_dout <= 8'd0; m_busy <= 1'b0;
            m_cnt <= 0; m_addr <= 32'd0; addr_n <= 0;
        end else if (!m_busy) begin
            m_avail <= 1'b0;
            if (rd_m && m_ready) begin
                m_busy <= 1'b1; m_ready <= 1'b0; m_cnt <= 0; m_addr <= addr_m;
                if (addr_n < 16) addr_log[addr_n] <= addr_m;
                addr_n <= addr_n + 1;
            end else begin
                m_ready <= 1'b1;
            end
        end else if (stall_after != 0 && m_cnt == stall_after) begin
            m_avail <= 1'b0;
        end else if (!m_avail) begin
            m_avail <= 1'b1;
            m_dout  <= pat(m_addr, m_cnt);
        end else begin
            m_avail <= 1'b0;
            m_cnt   <= m_cnt + 1;
            if (m_cnt == SB - 1) m_busy <= 1'b0;
        end
    end

    // Consumer side: log accepted bytes and done pulses.
    always @(negedge clk) begin
        if (m_clr) begin
            rx_q.delete();
            done_cnt <= 0;
        end else begin
            if (valid_m && ready) rx_q.push_back({last_m, data_m});
            if (done_m) done_cnt <= done_cnt + 1;
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        @(posedge clk); #1 m_clr = 1'b1;
        @(posedge clk); #1 m_clr = 1'b0;
    endtask

    task automatic start_pass(input logic s, input logic [31:0] a, input logic [15:0] f);
        @(posedge clk); #1;
        sel = s; start_addr = a; num_frames = f; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        @(negedge clk);
        while (busy_m && k < budget) begin @(negedge clk); k++; end
        check("idle_reached", busy_m, 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_addrs(input int n, input int budget);
        int k = 0;
        while (addr_n < n && k < budget) begin @(negedge clk); k++; end
        check("addr_wait", (addr_n >= n), 1);
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin @(negedge clk); k++; end
        check("rx_wait", (rx_q.size() >= n), 1);
    endtask

    task automatic check_stream(input string tag, input int n_sect, input bit exp_last);
        int errs = 0;
        int lasts = 0;
        logic [8:0] e;
        check({tag, "_len"}, rx_q.size(), n_sect * SB);
        for (int i = 0; i < rx_q.size() && i < n_sect * SB; i++) begin
            e = {exp_last && (i == n_sect * SB - 1), pat(exp_addrs[i / SB], i % SB)};
            if (rx_q[i] !== e) errs++;
            if (rx_q[i][8]) lasts++;
        end
        check({tag, "_data"}, errs, 0);
        check({tag, "_lasts"}, lasts, exp_last ? 1 : 0);
    endtask

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [15:0] f;
        int          n_addr;
        logic [31:0] e0, e1, e2;
        logic [15:0] e_fidx;
    } vec_t;
    vec_t tbl [5];

    initial begin
        n_checks = 0; n_fail = 0;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0; ready = 1'b1;
        sel = 1'b0; m_clr = 1'b0; stall_after = 0;
        start_addr = 32'd0; num_frames = 16'd0;

        tbl[0] = '{1'b0, 32'h0000_0200, 16'd3, 3, 32'h200, 32'h400, 32'h600, 16'd3};
        tbl[1] = '{1'b0, 32'hFFFF_FC00, 16'd3, 3, 32'hFFFF_FC00, 32'hFFFF_FE00, 32'h0, 16'd3};
        tbl[2] = '{1'b1, 32'h0000_0005, 16'd2, 2, 32'h5, 32'h6, 32'h0, 16'd2};
        tbl[3] = '{1'b0, 32'h0000_1234, 16'd0, 0, 32'h0, 32'h0, 32'h0, 16'd3};
        tbl[4] = '{1'b1, 32'hFFFF_FFFF, 16'd2, 2, 32'hFFFF_FFFF, 32'h0, 32'h0, 16'd2};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_rd", d0_rd, 0);
        check("rst_addr", d0_addr, 0);
        check("rst_valid", d0_valid, 0);
        check("rst_last", d0_last, 0);
        check("rst_done", d0_done, 0);
        check("rst_err", d0_err, 0);
        check("rst_fidx", d0_fidx, 0);
        check("rst_busy", d0_busy, 0);
        check("rst_rd1", d1_rd, 0);

        // Table-driven single passes, consumer always ready.
        for (int r = 0; r < 5; r++) begin
            clear_logs();
            start_pass(tbl[r].s, tbl[r].a, tbl[r].f);
            wait_idle(12000);
            exp_addrs[0] = tbl[r].e0; exp_addrs[1] = tbl[r].e1; exp_addrs[2] = tbl[r].e2;
            check($sformatf("r%0d_addr_n", r), addr_n, tbl[r].n_addr);
            for (int k = 0; k < tbl[r].n_addr; k++)
                check($sformatf("r%0d_addr%0d", r, k), addr_log[k], exp_addrs[k]);
            check_stream($sformatf("r%0d", r), tbl[r].n_addr, tbl[r].n_addr != 0);
            check($sformatf("r%0d_done", r), done_cnt, 1);
            check($sformatf("r%0d_fidx", r), fidx_m, tbl[r].e_fidx);
            check($sformatf("r%0d_err", r), err_m, 0);
        end

        // Backpressure: with no pops only two sectors fit.
        clear_logs();
        ready = 1'b0;
        start_pass(1'b0, 32'h200, 16'd3);
        repeat (3000) @(negedge clk);
        check("bp_two_sectors", addr_n, 2);
        check("bp_no_pop", rx_q.size(), 0);
        check("bp_busy", busy_m, 1);
        @(posedge clk); #1 ready = 1'b1;
        repeat (511) @(posedge clk);
        #1 ready = 1'b0;
        repeat (200) @(negedge clk);
        check("bp_511_pops", rx_q.size(), 511);
        check("bp_still_two", addr_n, 2);
        @(posedge clk); #1 ready = 1'b1;
        @(posedge clk); #1 ready = 1'b0;
        repeat (20) @(negedge clk);
        check("bp_third_rd", addr_n, 3);
        ready = 1'b1;
        wait_idle(6000);
        exp_addrs[0] = 32'h200; exp_addrs[1] = 32'h400; exp_addrs[2] = 32'h600;
        check_stream("bp", 3, 1'b1);
        check("bp_done", done_cnt, 1);

        // Loop mode, then drop loop to finish the pass.
        clear_logs();
        loop_en = 1'b1;
        start_pass(1'b0, 32'h200, 16'd2);
        wait_addrs(5, 8000);
        check("loop_a2", addr_log[2], 32'h200);
        check("loop_a3", addr_log[3], 32'h400);
        check("loop_a4", addr_log[4], 32'h200);
        check("loop_no_done", done_cnt, 0);
        #1 loop_en = 1'b0;
        wait_idle(6000);
        check("loop_addr_n", addr_n, 6);
        check("loop_a5", addr_log[5], 32'h400);
        for (int k = 0; k < 6; k++) exp_addrs[k] = (k % 2 == 0) ? 32'h200 : 32'h400;
        check_stream("loop", 6, 1'b1);
        check("loop_done", done_cnt, 1);
        check("loop_fidx", fidx_m, 2);

        // Graceful stop during the second sector.
        clear_logs();
        start_pass(1'b0, 32'h200, 16'd3);
        wait_rx(SB + 100, 4000);
        @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        wait_idle(4000);
        check("stop_addr_n", addr_n, 2);
        exp_addrs[0] = 32'h200; exp_addrs[1] = 32'h400;
        check_stream("stop", 2, 1'b0);
        check("stop_done", done_cnt, 1);
        check("stop_fidx", fidx_m, 2);
        check("stop_drained", valid_m, 0);

        // Read timeout after 10 bytes of a sector.
        stall_after = 10;
        ready = 1'b0;
        clear_logs();
        start_pass(1'b0, 32'h200, 16'd2);
        begin
            int k = 0;
            @(negedge clk);
            while (m_cnt != 10 && k < 200) begin @(negedge clk); k++; end
        end
        check("tmo_ten_bytes", m_cnt, 10);
        repeat (998) @(negedge clk);
        check("tmo_not_yet", err_m, 0);
        check("tmo_busy_before", busy_m, 1);
        repeat (2) @(negedge clk);
        check("tmo_error", err_m, 1);
        check("tmo_flushed", valid_m, 0);
        check("tmo_idle", busy_m, 0);
        check("tmo_rd_low", rd_m, 0);
        check("tmo_no_done", done_cnt, 0);
        stall_after = 0;
        ready = 1'b1;
        clear_logs();
        start_pass(1'b0, 32'h200, 16'd1);
        check("tmo_err_cleared", err_m, 0);
        wait_idle(3000);
        exp_addrs[0] = 32'h200;
        check_stream("tmo_restart", 1, 1'b1);

        // Asynchronous reset in the middle of a read.
        clear_logs();
        start_pass(1'b0, 32'h200, 16'd2);
        wait_rx(50, 2000);
        rst_n = 1'b0;
        #1;
        check("arst_busy", d0_busy, 0);
        check("arst_rd", d0_rd, 0);
        check("arst_valid", d0_valid, 0);
        check("arst_fidx", d0_fidx, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
